// File: rtl/kernel_sysid_checker.sv
// kernel_sysid_checker
// Avalon-MM master that reads the system-ID slave after reset or on a start
// pulse. It reads the ID word (address 0) and then the timestamp word
// (address 1), latches both, and compares them against build-time values.
// The result is reported as id_ok / ts_ok / timeout_err, qualified by done.
module kernel_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1533475449,
    parameter int unsigned TIMEOUT_CYCLES     = 255,   // 2..65535
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_DONE
    } state_t;

    // Last count value of a read phase; reaching it without data is a timeout.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        auto_q;
    logic        avm_address_q;
    logic        avm_read_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic        timeout_err_q;
    logic        busy_q;
    logic        done_q;

    logic        in_req;
    logic        accept;
    logic        capture;
    logic        expired;
    logic        id_ok_d;
    logic        ts_ok_d;

    // Handshake decode and comparisons for the current cycle.
    always_comb begin
        in_req  = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
        accept  = in_req && avm_read_q && !avm_waitrequest;
        // Read data counts only in a WAIT state or on the accepting REQ edge.
        capture = avm_readdatavalid &&
                  (accept || (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT));
        expired = (cnt_q == CNT_LAST);
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (avm_readdata == EXPECTED_TIMESTAMP);
    end

    // Check sequencer: all outputs are registered here.
    // NOTE: non-blocking assignments throughout, so every branch sees the
    // pre-edge values of all state regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the captured words are plain registers, not a memory, so
            // they take part in the reset like every other output.
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            auto_q        <= AUTO_START;
            avm_address_q <= 1'b0;
            avm_read_q    <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start || auto_q) begin
                        auto_q        <= 1'b0;
                        done_q        <= 1'b0;
                        id_ok_q       <= 1'b0;
                        ts_ok_q       <= 1'b0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                        avm_read_q    <= 1'b1;
                        avm_address_q <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= ST_ID_REQ;
                    end
                end

                ST_ID_REQ, ST_ID_WAIT: begin
                    if (capture) begin
                        id_value_q    <= avm_readdata;
                        avm_read_q    <= 1'b1;
                        avm_address_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_TS_REQ;
                    end else if (expired) begin
                        // Both ok flags were cleared at start and stay 0.
                        avm_read_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (accept) begin
                            avm_read_q <= 1'b0;
                            state_q    <= ST_ID_WAIT;
                        end
                    end
                end

                ST_TS_REQ, ST_TS_WAIT: begin
                    if (capture) begin
                        ts_value_q <= avm_readdata;
                        avm_read_q <= 1'b0;
                        id_ok_q    <= id_ok_d;
                        ts_ok_q    <= ts_ok_d;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (expired) begin
                        // The ID word was captured, so its verdict still holds.
                        avm_read_q    <= 1'b0;
                        id_ok_q       <= id_ok_d;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (accept) begin
                            avm_read_q <= 1'b0;
                            state_q    <= ST_TS_WAIT;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// tb_kernel_sysid_checker
// Randomized bench with a behavioural sysid slave. Each issued check pushes
// its predicted outcome (values, flags and completion cycle) into a queue; a
// monitor pops and compares whenever done rises. A second instance built
// with AUTO_START=0 shows the idle-after-reset behaviour.
module tb_kernel_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1533475449;
    localparam int          T      = 8;
    localparam int          NEVER  = 1 << 20;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic        busy;
    logic        done;

    logic        addr2, read2, id_ok2, ts_ok2, to2, busy2, done2;
    logic [31:0] id_value2, ts_value2;

    kernel_sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (T),
        .AUTO_START        (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout_err      (timeout_err),
        .busy             (busy),
        .done             (done)
    );

    kernel_sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (T),
        .AUTO_START        (1'b0)
    ) dut_manual (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (1'b0),
        .avm_address      (addr2),
        .avm_read         (read2),
        .avm_waitrequest  (1'b0),
        .avm_readdata     (32'd0),
        .avm_readdatavalid(1'b0),
        .id_value         (id_value2),
        .ts_value         (ts_value2),
        .id_ok            (id_ok2),
        .ts_ok            (ts_ok2),
        .timeout_err      (to2),
        .busy             (busy2),
        .done             (done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- slave configuration and behavioural slave -------------
    int          wait_n [2];
    int          lat_n  [2];
    bit          drop   [2];
    logic [31:0] sdata  [2];
    int          spur_req = 0;
    int          addr_log [$];

    initial begin : slave
        bit          in_req;
        int          stall_left;
        int          pend_lat;
        bit          pend_drop;
        logic [31:0] pend_data;
        int          ph;
        int          spur_ack;
        in_req = 0; stall_left = 0; pend_lat = 0; pend_drop = 0; pend_data = '0;
        ph = 0; spur_ack = 0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(posedge clock);
            #1;
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
            if (!reset_n) begin
                in_req = 0; stall_left = 0; pend_lat = 0;
            end else begin
                if (pend_lat > 0) begin
                    pend_lat--;
                    if (pend_lat == 0 && !pend_drop) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end
                if (avm_read) begin
                    ph = avm_address ? 1 : 0;
                    if (!in_req) begin
                        in_req     = 1;
                        stall_left = wait_n[ph];
                    end
                    if (stall_left > 0) begin
                        avm_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        // Accepted on the coming edge.
                        in_req = 0;
                        addr_log.push_back(ph);
                        if (lat_n[ph] == 0) begin
                            if (!drop[ph]) begin
                                avm_readdatavalid = 1'b1;
                                avm_readdata      = sdata[ph];
                            end
                        end else begin
                            pend_lat  = lat_n[ph];
                            pend_drop = drop[ph];
                            pend_data = sdata[ph];
                        end
                    end
                end else begin
                    in_req = 0;
                end
                if (spur_req != spur_ack) begin
                    spur_ack          = spur_req;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = $urandom();
                end
            end
        end
    end

    // ---------------- reference model and scoreboard -------------------------
    typedef struct {
        logic [31:0] id_val;
        logic [31:0] ts_val;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    // A read phase lasts stall + 1 (accept) + latency edges; it times out
    // when that exceeds T edges or the data never comes.
    task automatic predict(input int e0);
        exp_t e;
        int   n_id;
        int   n_ts;
        n_id = drop[0] ? NEVER : wait_n[0] + 1 + lat_n[0];
        n_ts = drop[1] ? NEVER : wait_n[1] + 1 + lat_n[1];
        e.id_ok = 1'b0; e.ts_ok = 1'b0; e.to = 1'b0;
        if (n_id > T) begin
            e.to  = 1'b1;
            e.cyc = e0 + T;
        end else begin
            m_id    = sdata[0];
            e.id_ok = (m_id == EXP_ID);
            if (n_ts > T) begin
                e.to  = 1'b1;
                e.cyc = e0 + n_id + T;
            end else begin
                m_ts    = sdata[1];
                e.ts_ok = (m_ts == EXP_TS);
                e.cyc   = e0 + n_id + n_ts;
            end
        end
        e.id_val = m_id;
        e.ts_val = m_ts;
        exp_q.push_back(e);
    endtask

    // Monitor: compare on every rising done; check stall stability each cycle.
    logic done_prev = 1'b0;
    logic prev_read = 1'b0;
    logic prev_wr   = 1'b0;
    logic prev_addr = 1'b0;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n && prev_read && prev_wr && !timeout_err) begin
            check("read_held_in_stall", avm_read, 1);
            check("addr_held_in_stall", avm_address, prev_addr);
        end
        if (reset_n && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done rose at cycle %0d, expected no completion", cyc);
            end else begin
                e = exp_q.pop_front();
                check("id_value",    id_value,    e.id_val);
                check("ts_value",    ts_value,    e.ts_val);
                check("id_ok",       id_ok,       e.id_ok);
                check("ts_ok",       ts_ok,       e.ts_ok);
                check("timeout_err", timeout_err, e.to);
                check("busy_at_done", busy,       0);
                check("read_at_done", avm_read,   0);
                check("done_cycle",  cyc,         e.cyc);
            end
        end
        done_prev = done;
        prev_read = avm_read;
        prev_wr   = avm_waitrequest;
        prev_addr = avm_address;
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_cfg(input int w0, input int l0, input bit d0, input logic [31:0] v0,
                           input int w1, input int l1, input bit d1, input logic [31:0] v1);
        wait_n[0] = w0; lat_n[0] = l0; drop[0] = d0; sdata[0] = v0;
        wait_n[1] = w1; lat_n[1] = l1; drop[1] = d1; sdata[1] = v1;
    endtask

    task automatic issue_start();
        tick();
        start = 1'b1;
        predict(cyc + 1);
        tick();
        start = 1'b0;
        check("start_busy",      busy,        1);
        check("start_done_clr",  done,        0);
        check("start_read",      avm_read,    1);
        check("start_addr",      avm_address, 0);
        check("start_to_clr",    timeout_err, 0);
    endtask

    task automatic wait_complete();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_wait: %0d checks still pending after %0d cycles, expected 0",
                     exp_q.size(), n);
            exp_q.delete();
        end
        repeat (5) tick();
    endtask

    task automatic check_manual_idle(input string name);
        check(name, {addr2, read2, id_ok2, ts_ok2, to2, busy2, done2}, 0);
    endtask

    initial begin : stimulus
        int base;
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        set_cfg(0, 1, 0, EXP_ID, 0, 1, 0, EXP_TS);
        repeat (3) @(negedge clock);

        // Reset values on both instances.
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", ts_value, 0);
        check("rst_ctl", {avm_address, avm_read, id_ok, ts_ok, timeout_err, busy, done}, 0);
        check("rst_manual_values", {id_value2, ts_value2}, 0);
        check_manual_idle("rst_manual_ctl");

        // Auto-start after release: done four edges later, address 0 then 1.
        base = addr_log.size();
        predict(cyc + 1);
        reset_n = 1'b1;
        wait_complete();
        check("addr_seq_count", addr_log.size() - base, 2);
        check("addr_seq_first",  (addr_log.size() > base)     ? addr_log[base]     : -1, 0);
        check("addr_seq_second", (addr_log.size() > base + 1) ? addr_log[base + 1] : -1, 1);
        check_manual_idle("manual_stays_idle");

        // Wrong timestamp word.
        set_cfg(0, 1, 0, EXP_ID, 0, 1, 0, 32'h5B6D_0000);
        issue_start();
        wait_complete();

        // Five-cycle stall on the ID read.
        set_cfg(5, 1, 0, EXP_ID, 0, 1, 0, EXP_TS);
        issue_start();
        wait_complete();

        // Timestamp data never arrives: timeout in the TS phase.
        set_cfg(0, 1, 0, EXP_ID, 0, 1, 1, EXP_TS);
        issue_start();
        wait_complete();

        // start while busy is ignored; spurious data in IDLE is ignored.
        set_cfg(2, 2, 0, EXP_ID, 1, 2, 0, EXP_TS);
        issue_start();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_complete();
        spur_req++;
        repeat (3) tick();
        check("spurious_id_ignored", id_value, m_id);
        check("spurious_no_busy", busy, 0);
        issue_start();
        wait_complete();

        // Data coincident with acceptance on both reads: done after E2.
        set_cfg(0, 0, 0, EXP_ID, 0, 0, 0, EXP_TS);
        issue_start();
        wait_complete();

        // ID data never arrives: timeout in the ID phase.
        set_cfg(1, 1, 1, 32'h1234_5678, 0, 1, 0, EXP_TS);
        issue_start();
        wait_complete();

        // Randomized stalls, latencies, drops and data.
        for (int i = 0; i < 25; i++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom()),
                    $urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom()));
            issue_start();
            wait_complete();
        end

        // Reset asserted while waiting for timestamp data.
        set_cfg(0, 1, 0, EXP_ID, 0, 4, 0, EXP_TS);
        issue_start();
        n = 0;
        while (!(busy && avm_address && !avm_read) && n < 20) begin
            tick();
            n++;
        end
        check("reached_ts_wait", busy && avm_address && !avm_read, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_id_value", id_value, 0);
        check("midrst_ts_value", ts_value, 0);
        check("midrst_ctl", {avm_address, avm_read, id_ok, ts_ok, timeout_err, busy, done}, 0);
        exp_q.delete();
        m_id = '0;
        m_ts = '0;
        repeat (2) @(negedge clock);
        set_cfg(0, 1, 0, EXP_ID, 0, 1, 0, EXP_TS);
        predict(cyc + 1);
        reset_n = 1'b1;
        wait_complete();
        check_manual_idle("manual_idle_after_midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
